// File: rtl/apb_slv_pkg.sv
// rtl/apb_slv_pkg.sv - shared types and constants for the APB register-bank slave
package apb_slv_pkg;

    // Transfer sequencing states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of the wait-state counter (supports 0..15 wait cycles)
    localparam int CNT_W = 4;

    // Default identification word returned by the read-only ID register
    localparam logic [31:0] DEF_ID_VAL = 32'h0A5B_0001;

    // Low bit index of element idx in a flattened vector of width-bit elements
    function automatic int slice_lo(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/apb_slv_wait_ctr.sv
// rtl/apb_slv_wait_ctr.sv - loadable wait-state down-counter with last/zero flags
module apb_slv_wait_ctr
    import apb_slv_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             last,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    // Load on transfer setup, otherwise count down once per wait cycle and hold at zero
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign last = (cnt == CNT_W'(1));
    assign zero = (cnt == '0);

endmodule

// File: rtl/apb_slv_regfile.sv
// rtl/apb_slv_regfile.sv - APB slave register bank with wait states; byte strobes under APB_SLV_PSTRB_EN
module apb_slv_regfile
    import apb_slv_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 16,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    OFS_WIDTH  = 8,
    parameter int                    NUM_REGS   = 4,
    parameter int                    WAIT_CYC   = 1,
    parameter logic [DATA_WIDTH-1:0] ID_VAL     = DATA_WIDTH'(DEF_ID_VAL)
) (
    input  logic                           pclk,
    input  logic                           preset,
    input  logic                           psel,
    input  logic                           penable,
    input  logic                           pwrite,
    input  logic [ADDR_WIDTH-1:0]          paddr,
    input  logic [DATA_WIDTH-1:0]          pwdata,
`ifdef APB_SLV_PSTRB_EN
    input  logic [DATA_WIDTH/8-1:0]        pstrb,
`endif
    output logic [DATA_WIDTH-1:0]          prdata,
    output logic                           pready,
    output logic                           pslverr,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
    output logic [NUM_REGS-1:0]            wr_pulse
);

    localparam int                 NB     = DATA_WIDTH / 8;
    localparam int                 NRW    = NUM_REGS - 1;
    localparam logic [OFS_WIDTH:0] ID_OFS = (OFS_WIDTH + 1)'(NUM_REGS - 1);

    state_t                  state;
    state_t                  state_nxt;
    logic                    setup;
    logic                    ctr_load;
    logic                    ctr_dec;
    logic                    ctr_last;
    logic                    ctr_zero_unused;

    logic                    cap_write;
    logic [OFS_WIDTH-1:0]    cap_ofs;
    logic [DATA_WIDTH-1:0]   cap_wdata;
    logic [NB-1:0]           cap_strb;
    logic [NB-1:0]           live_strb;

    logic                    txn_write;
    logic [OFS_WIDTH-1:0]    txn_ofs;
    logic [DATA_WIDTH-1:0]   txn_wdata;
    logic [NB-1:0]           txn_strb;
    logic [OFS_WIDTH:0]      ofs_ext;
    logic                    txn_err;
    logic                    commit;
    logic                    do_write;
    logic [DATA_WIDTH-1:0]   wmask;
    logic [DATA_WIDTH-1:0]   rd_val;
    logic [NUM_REGS-1:0]     wr_sel;

    logic [DATA_WIDTH-1:0]   regs [NRW];

`ifdef APB_SLV_PSTRB_EN
    assign live_strb = pstrb;
`else
    assign live_strb = '1;
`endif

    // Upper address bits are decoded upstream and intentionally ignored here
    if (ADDR_WIDTH > OFS_WIDTH) begin : g_hi_addr
        logic paddr_hi_unused;
        assign paddr_hi_unused = ^paddr[ADDR_WIDTH-1:OFS_WIDTH];
    end

    assign setup = psel && !penable;

    apb_slv_wait_ctr u_wait_ctr (
        .clk      (pclk),
        .rst      (preset),
        .load     (ctr_load),
        .load_val (CNT_W'(WAIT_CYC)),
        .dec      (ctr_dec),
        .last     (ctr_last),
        .zero     (ctr_zero_unused)
    );

    // Next-state logic: setup starts a transfer, psel drop in WAIT aborts it
    always_comb begin
        state_nxt = state;
        ctr_load  = 1'b0;
        ctr_dec   = 1'b0;
        case (state)
            IDLE: begin
                if (setup) begin
                    ctr_load  = 1'b1;
                    state_nxt = (WAIT_CYC == 0) ? DONE : WAIT;
                end
            end
            WAIT: begin
                if (!psel) begin
                    state_nxt = IDLE;
                end else if (ctr_last) begin
                    state_nxt = DONE;
                end else begin
                    ctr_dec = 1'b1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // With zero wait states the transfer completes on the setup edge, so use live bus fields then
    always_comb begin
        if (state == IDLE) begin
            txn_write = pwrite;
            txn_ofs   = paddr[OFS_WIDTH-1:0];
            txn_wdata = pwdata;
            txn_strb  = live_strb;
        end else begin
            txn_write = cap_write;
            txn_ofs   = cap_ofs;
            txn_wdata = cap_wdata;
            txn_strb  = cap_strb;
        end
    end

    assign ofs_ext  = {1'b0, txn_ofs};
    assign txn_err  = (ofs_ext > ID_OFS) || (txn_write && (ofs_ext == ID_OFS));
    assign commit   = (state_nxt == DONE);
    assign do_write = commit && txn_write && !txn_err;

    // Byte-lane write mask and read/write register decode
    always_comb begin
        wmask  = '0;
        rd_val = '0;
        wr_sel = '0;
        for (int b = 0; b < NB; b++) begin
            wmask[b*8 +: 8] = {8{txn_strb[b]}};
        end
        for (int i = 0; i < NRW; i++) begin
            if (ofs_ext == (OFS_WIDTH + 1)'(i)) begin
                rd_val    = regs[i];
                wr_sel[i] = do_write;
            end
        end
        if (ofs_ext == ID_OFS) begin
            rd_val = ID_VAL;
        end
    end

    // Freeze transfer fields at setup so later bus changes are ignored
    always_ff @(posedge pclk) begin
        if (state == IDLE && setup) begin
            cap_write <= pwrite;
            cap_ofs   <= paddr[OFS_WIDTH-1:0];
            cap_wdata <= pwdata;
            cap_strb  <= live_strb;
        end
    end

    // Register array: commit selected bytes on the edge entering DONE
    always_ff @(posedge pclk) begin
        if (preset) begin
            for (int i = 0; i < NRW; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NRW; i++) begin
                if (wr_sel[i]) begin
                    regs[i] <= (regs[i] & ~wmask) | (txn_wdata & wmask);
                end
            end
        end
    end

    // State and registered bus response outputs
    always_ff @(posedge pclk) begin
        if (preset) begin
            state    <= IDLE;
            pready   <= 1'b0;
            pslverr  <= 1'b0;
            prdata   <= '0;
            wr_pulse <= '0;
        end else begin
            state    <= state_nxt;
            pready   <= commit;
            pslverr  <= commit && txn_err;
            prdata   <= (commit && !txn_write && !txn_err) ? rd_val : '0;
            wr_pulse <= wr_sel;
        end
    end

    // Flattened register view for fabric logic, ID word in the top slice
    always_comb begin
        reg_q = '0;
        for (int i = 0; i < NRW; i++) begin
            reg_q[slice_lo(i, DATA_WIDTH) +: DATA_WIDTH] = regs[i];
        end
        reg_q[slice_lo(NRW, DATA_WIDTH) +: DATA_WIDTH] = ID_VAL;
    end

endmodule

// File: tb/tb_apb_slv_regfile.sv
// tb/tb_apb_slv_regfile.sv - directed self-checking bench for apb_slv_regfile (WAIT_CYC=1 and WAIT_CYC=0 instances)
module tb_apb_slv_regfile;

    localparam logic [127:0] RQ_RST = {32'h0A5B0001, 96'h0};
    localparam logic [31:0]  ID     = 32'h0A5B0001;

    logic         pclk = 1'b0;
    logic         preset;
    logic         psel1;
    logic         psel0;
    logic         penable;
    logic         pwrite;
    logic [15:0]  paddr;
    logic [31:0]  pwdata;
`ifdef APB_SLV_PSTRB_EN
    logic [3:0]   pstrb_v;
`else
    logic [3:0]   strb_unused;
`endif

    logic [31:0]  prdata1, prdata0;
    logic         pready1, pready0;
    logic         pslverr1, pslverr0;
    logic [127:0] reg_q1, reg_q0;
    logic [3:0]   wr_pulse1, wr_pulse0;

    int n_run  = 0;
    int n_fail = 0;
    int wp_cnt[4] = '{0, 0, 0, 0};
    int snap[4];

    logic [31:0]  rd;
    logic         err;
    int           lat;
    logic [127:0] rq;
    logic [3:0]   wp;
    logic         saw;

    always #5 pclk = ~pclk;

    apb_slv_regfile #(.WAIT_CYC(1)) dut1 (
        .pclk     (pclk),
        .preset   (preset),
        .psel     (psel1),
        .penable  (penable),
        .pwrite   (pwrite),
        .paddr    (paddr),
        .pwdata   (pwdata),
`ifdef APB_SLV_PSTRB_EN
        .pstrb    (pstrb_v),
`endif
        .prdata   (prdata1),
        .pready   (pready1),
        .pslverr  (pslverr1),
        .reg_q    (reg_q1),
        .wr_pulse (wr_pulse1)
    );

    apb_slv_regfile #(.WAIT_CYC(0)) dut0 (
        .pclk     (pclk),
        .preset   (preset),
        .psel     (psel0),
        .penable  (penable),
        .pwrite   (pwrite),
        .paddr    (paddr),
        .pwdata   (pwdata),
`ifdef APB_SLV_PSTRB_EN
        .pstrb    (pstrb_v),
`endif
        .prdata   (prdata0),
        .pready   (pready0),
        .pslverr  (pslverr0),
        .reg_q    (reg_q0),
        .wr_pulse (wr_pulse0)
    );

    always @(negedge pclk) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_pulse1[i] === 1'b1) wp_cnt[i]++;
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        @(posedge pclk); #1;
        psel1 = 1'b0; psel0 = 1'b0; penable = 1'b0;
    endtask

    // One transfer: setup, then access with scrambled paddr/pwdata until pready (bounded)
    task automatic xfer(input bit which, input bit wr, input logic [15:0] addr,
                        input logic [31:0] data, input logic [3:0] strb,
                        output logic [31:0] o_rd, output logic o_err, output int o_lat,
                        output logic [127:0] o_rq, output logic [3:0] o_wp);
        bit done;
        done = 1'b0; o_rd = '0; o_err = 1'b0; o_lat = -1; o_rq = '0; o_wp = '0;
        @(posedge pclk); #1;
        psel1 = !which; psel0 = which; penable = 1'b0;
        pwrite = wr; paddr = addr; pwdata = data;
`ifdef APB_SLV_PSTRB_EN
        pstrb_v = strb;
`else
        strb_unused = strb;
`endif
        @(posedge pclk); #1;
        penable = 1'b1; paddr = ~addr; pwdata = ~data;
`ifdef APB_SLV_PSTRB_EN
        pstrb_v = ~strb;
`endif
        for (int k = 1; k <= 20 && !done; k++) begin
            @(negedge pclk);
            if ((which ? pready0 : pready1) === 1'b1) begin
                done  = 1'b1;
                o_lat = k;
                o_rd  = which ? prdata0 : prdata1;
                o_err = which ? pslverr0 : pslverr1;
                o_rq  = which ? reg_q0 : reg_q1;
                o_wp  = which ? wr_pulse0 : wr_pulse1;
            end else begin
                chk("prdata_zero_while_waiting", which ? prdata0 : prdata1, 0);
            end
        end
        #1;
    endtask

    initial begin
        psel1 = 0; psel0 = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0; preset = 1;
        repeat (3) @(posedge pclk);
        #1 preset = 0;
        @(negedge pclk);
        chk("rst_pready", {pready1, pready0}, 0);
        chk("rst_pslverr", {pslverr1, pslverr0}, 0);
        chk("rst_prdata", prdata1, 0);
        chk("rst_wr_pulse", wr_pulse1, 0);
        chk("rst_reg_q", reg_q1, RQ_RST);

        xfer(0, 0, 16'h4000, 32'h0, 4'hF, rd, err, lat, rq, wp);
        chk("rd0_latency", lat, 2);
        chk("rd0_data", rd, 0);
        chk("rd0_err", err, 0);

        snap = wp_cnt;
        xfer(0, 1, 16'h4000, 32'h1, 4'hF, rd, err, lat, rq, wp);
        chk("wr0_latency", lat, 2);
        chk("wr0_err", err, 0);
        chk("wr0_pulse", wp, 4'b0001);
        chk("wr0_reg_q", rq, RQ_RST | 128'h1);
        chk("wr0_pulse_once", wp_cnt[0] - snap[0], 1);
        xfer(0, 0, 16'h4000, 32'h0, 4'hF, rd, err, lat, rq, wp);
        chk("rd0_after_wr", rd, 32'h1);

        snap = wp_cnt;
        xfer(0, 1, 16'h4001, 32'h1, 4'hF, rd, err, lat, rq, wp);
        chk("wr1_pulse", wp, 4'b0010);
        chk("wr1_pulse_once", wp_cnt[1] - snap[1], 1);
        chk("wr1_no_pulse0", wp_cnt[0] - snap[0], 0);
        xfer(0, 0, 16'h4001, 32'h0, 4'hF, rd, err, lat, rq, wp);
        chk("rd1_data", rd, 32'h1);
        xfer(0, 0, 16'h4000, 32'h0, 4'hF, rd, err, lat, rq, wp);
        chk("rd0_still", rd, 32'h1);

        xfer(0, 0, 16'h4003, 32'h0, 4'hF, rd, err, lat, rq, wp);
        chk("rd_id_data", rd, ID);
        chk("rd_id_err", err, 0);
        snap = wp_cnt;
        xfer(0, 1, 16'h4003, 32'h12345678, 4'hF, rd, err, lat, rq, wp);
        chk("wr_id_err", err, 1);
        chk("wr_id_no_pulse", wp_cnt[3] - snap[3], 0);
        xfer(0, 0, 16'h4003, 32'h0, 4'hF, rd, err, lat, rq, wp);
        chk("rd_id_unchanged", rd, ID);
        xfer(0, 0, 16'h4010, 32'h0, 4'hF, rd, err, lat, rq, wp);
        chk("rd_oob_err", err, 1);
        chk("rd_oob_data", rd, 0);

        idle();
        @(posedge pclk); #1;
        psel1 = 1; penable = 1; pwrite = 0; paddr = 16'h4000;
        saw = 0;
        repeat (4) begin
            @(negedge pclk);
            if (pready1 !== 1'b0) saw = 1;
        end
        chk("penable_without_setup_ignored", saw, 0);

        idle();
        snap = wp_cnt;
        @(posedge pclk); #1;
        psel1 = 1; penable = 0; pwrite = 1; paddr = 16'h4002; pwdata = 32'hDEADBEEF;
        @(posedge pclk); #1;
        psel1 = 0; penable = 0;
        saw = 0;
        repeat (4) begin
            @(negedge pclk);
            if (pready1 !== 1'b0) saw = 1;
        end
        chk("abort_no_pready", saw, 0);
        chk("abort_no_pulse", wp_cnt[2] - snap[2], 0);
        chk("abort_reg_q", reg_q1, RQ_RST | (128'h1 << 32) | 128'h1);
        xfer(0, 0, 16'h4002, 32'h0, 4'hF, rd, err, lat, rq, wp);
        chk("abort_rd2", rd, 0);

        @(posedge pclk); #1;
        psel1 = 1; penable = 0; pwrite = 1; paddr = 16'h4002; pwdata = 32'hDEADBEEF;
        @(posedge pclk); #1;
        penable = 1; preset = 1;
        @(posedge pclk); #1;
        preset = 0; psel1 = 0; penable = 0;
        @(negedge pclk);
        chk("preset_mid_no_pready", pready1, 0);
        chk("preset_mid_reg_q", reg_q1, RQ_RST);
        chk("preset_mid_prdata", prdata1, 0);
        xfer(0, 0, 16'h4000, 32'h0, 4'hF, rd, err, lat, rq, wp);
        chk("preset_mid_rd0", rd, 0);

        xfer(1, 1, 16'h4001, 32'hCAFEF00D, 4'hF, rd, err, lat, rq, wp);
        chk("w0_wr_latency", lat, 1);
        chk("w0_wr_err", err, 0);
        chk("w0_wr_pulse", wp, 4'b0010);
        chk("w0_wr_reg_q", rq, RQ_RST | (128'hCAFEF00D << 32));
        xfer(1, 0, 16'h4001, 32'h0, 4'hF, rd, err, lat, rq, wp);
        chk("w0_rd_latency", lat, 1);
        chk("w0_rd_data", rd, 32'hCAFEF00D);
        xfer(1, 0, 16'h4003, 32'h0, 4'hF, rd, err, lat, rq, wp);
        chk("w0_rd_id", rd, ID);

`ifdef APB_SLV_PSTRB_EN
        xfer(0, 1, 16'h4000, 32'h11223344, 4'hF, rd, err, lat, rq, wp);
        xfer(0, 1, 16'h4000, 32'hAABBCCDD, 4'b0101, rd, err, lat, rq, wp);
        chk("strb_wr_err", err, 0);
        xfer(0, 0, 16'h4000, 32'h0, 4'hF, rd, err, lat, rq, wp);
        chk("strb_rd_merge", rd, 32'h11BB33DD);
        xfer(0, 1, 16'h4000, 32'hFFFFFFFF, 4'b0000, rd, err, lat, rq, wp);
        chk("strb0_pulse", wp, 4'b0001);
        chk("strb0_err", err, 0);
        xfer(0, 0, 16'h4000, 32'h0, 4'hF, rd, err, lat, rq, wp);
        chk("strb0_unchanged", rd, 32'h11BB33DD);
`endif

        idle();
        repeat (2) @(posedge pclk);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
